// File: rtl/convert_to_multisymbols_seq_if.sv
// Operand/result handshake bundle for the number-to-symbol converter.
// The master drives operands and the result acknowledge; the slave is the converter.
interface convert_to_multisymbols_seq_if #(
   parameter int unsigned INPUTBITWIDTH        = 1024,
   parameter int unsigned NUMSYMBOLS           = 64,
   parameter int unsigned OUTPUTSYMBOLBITWIDTH = 17
);
   logic                            in_valid;
   logic                            in_ready;
   logic [INPUTBITWIDTH-1:0]        data_in;
   logic [INPUTBITWIDTH-1:0]        dataaux_in;
   logic                            out_valid;
   logic                            out_ready;
   logic [OUTPUTSYMBOLBITWIDTH-1:0] data_out [NUMSYMBOLS];
   logic                            carry_out;

   modport master (
      output in_valid, data_in, dataaux_in, out_ready,
      input  in_ready, out_valid, data_out, carry_out
   );

   modport slave (
      input  in_valid, data_in, dataaux_in, out_ready,
      output in_ready, out_valid, data_out, carry_out
   );
endinterface

// File: rtl/convert_to_multisymbols_seq.sv
// Converts a (data + aux) binary number into NUMSYMBOLS radix-2^LOGRADIX symbols,
// resolving the carry chain SYMBOLSPERCYCLE symbols per clock.
module convert_to_multisymbols_seq #(
   parameter int unsigned INPUTBITWIDTH        = 1024,
   parameter int unsigned NUMSYMBOLS           = 64,
   parameter int unsigned LOGRADIX             = 16,
   parameter int unsigned OUTPUTSYMBOLBITWIDTH = 17,
   parameter int unsigned SYMBOLSPERCYCLE      = 16,
   parameter int unsigned USEDUALINPUT         = 1
) (
   input logic                          clk,
   input logic                          reset,
   convert_to_multisymbols_seq_if.slave bus
);

   localparam int unsigned TOTALBITS = NUMSYMBOLS * LOGRADIX;
   localparam int unsigned CHUNKBITS = SYMBOLSPERCYCLE * LOGRADIX;
   localparam int unsigned NUMCHUNKS = NUMSYMBOLS / SYMBOLSPERCYCLE;
   localparam int unsigned CNTW      = (NUMCHUNKS > 1) ? $clog2(NUMCHUNKS) : 1;

   if (INPUTBITWIDTH == 0 || NUMSYMBOLS == 0 || LOGRADIX == 0 || SYMBOLSPERCYCLE == 0) begin : g_bad_zero
      $error("convert_to_multisymbols_seq: parameters must be positive");
   end
   if (OUTPUTSYMBOLBITWIDTH < LOGRADIX) begin : g_bad_symwidth
      $error("convert_to_multisymbols_seq: OUTPUTSYMBOLBITWIDTH must be >= LOGRADIX");
   end
   if ((NUMSYMBOLS % SYMBOLSPERCYCLE) != 0) begin : g_bad_chunking
      $error("convert_to_multisymbols_seq: SYMBOLSPERCYCLE must divide NUMSYMBOLS");
   end
   if (TOTALBITS < INPUTBITWIDTH) begin : g_bad_capacity
      $error("convert_to_multisymbols_seq: NUMSYMBOLS*LOGRADIX must cover INPUTBITWIDTH");
   end
   if (USEDUALINPUT > 1) begin : g_bad_dual
      $error("convert_to_multisymbols_seq: USEDUALINPUT must be 0 or 1");
   end

   typedef enum logic [1:0] {StIdle, StConvert, StDone} state_t;

   state_t                state;
   logic [TOTALBITS-1:0]  opa;
   logic [TOTALBITS-1:0]  opb;
   logic                  carry;
   logic [CNTW-1:0]       cnt;
   logic                  out_valid_r;
   logic                  carry_out_r;
   logic [LOGRADIX-1:0]   sym [NUMSYMBOLS];
   logic [CHUNKBITS:0]    chunk_sum;
   logic                  last_chunk;

   // Operands are shifted down one chunk per cycle, so the adder always reads the low chunk.
   always_comb begin
      chunk_sum = {1'b0, opa[CHUNKBITS-1:0]} + {1'b0, opb[CHUNKBITS-1:0]}
                + (CHUNKBITS+1)'(carry);
   end

   assign last_chunk = (cnt == CNTW'(NUMCHUNKS - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= StIdle;
         opa         <= '0;
         opb         <= '0;
         carry       <= 1'b0;
         cnt         <= '0;
         out_valid_r <= 1'b0;
         carry_out_r <= 1'b0;
         for (int i = 0; i < int'(NUMSYMBOLS); i++) begin
            sym[i] <= '0;
         end
      end else begin
         unique case (state)
            StIdle: begin
               if (bus.in_valid) begin
                  opa   <= TOTALBITS'(bus.data_in);
                  opb   <= (USEDUALINPUT != 0) ? TOTALBITS'(bus.dataaux_in) : '0;
                  carry <= 1'b0;
                  cnt   <= '0;
                  state <= StConvert;
               end
            end
            StConvert: begin
               for (int k = 0; k < int'(NUMCHUNKS); k++) begin
                  if (cnt == CNTW'(k)) begin
                     for (int j = 0; j < int'(SYMBOLSPERCYCLE); j++) begin
                        sym[k*SYMBOLSPERCYCLE + j] <= chunk_sum[j*LOGRADIX +: LOGRADIX];
                     end
                  end
               end
               opa   <= opa >> CHUNKBITS;
               opb   <= opb >> CHUNKBITS;
               carry <= chunk_sum[CHUNKBITS];
               cnt   <= cnt + CNTW'(1);
               if (last_chunk) begin
                  carry_out_r <= chunk_sum[CHUNKBITS];
                  out_valid_r <= 1'b1;
                  state       <= StDone;
               end
            end
            StDone: begin
               // Symbols stay put after the handshake until the next conversion overwrites them.
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  state       <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign bus.in_ready  = (state == StIdle);
   assign bus.out_valid = out_valid_r;
   assign bus.carry_out = carry_out_r;

   always_comb begin
      for (int i = 0; i < int'(NUMSYMBOLS); i++) begin
         bus.data_out[i] = OUTPUTSYMBOLBITWIDTH'(sym[i]);
      end
   end

endmodule
